// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards with an ID_EX bubble, flushes IF_ID on a taken
// branch, and freezes the whole pipeline while a variable-latency data-memory
// access is outstanding. A watchdog moves to a terminal ERR state if the
// memory never acknowledges within TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-low reset
//   ID_EX_MemRead_i/RegRT_i   load in EX and its destination register
//   IF_ID_RegRS_i/RegRT_i     source registers of the instruction in ID
//   Branch_taken_i            branch resolved taken in ID
//   MEM_access_i, dmem_ack_i  memory access in MEM / completion this cycle
//   dmem_req_o                data memory request
//   *_we_o, IF_ID_flush_o,    pipeline register enables and NOP/bubble
//   ID_EX_bubble_o            controls (combinational, act this cycle)
//   err_o                     sticky memory-timeout error
//   stall_cnt_o               saturating count of frozen/stalled cycles
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RegRT_i,
  input  logic [4:0]       IF_ID_RegRS_i,
  input  logic [4:0]       IF_ID_RegRT_i,
  input  logic             Branch_taken_i,
  input  logic             MEM_access_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             PC_we_o,
  output logic             IF_ID_we_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_we_o,
  output logic             ID_EX_bubble_o,
  output logic             EX_MEM_we_o,
  output logic             MEM_WB_we_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               freeze_c;
  logic               load_use_c;
  logic               req_c;

  // Load in EX writes a register the instruction in ID reads ($0 never hazards).
  always_comb begin
    load_use_c = ID_EX_MemRead_i && (ID_EX_RegRT_i != 5'd0) &&
                 ((ID_EX_RegRT_i == IF_ID_RegRS_i) ||
                  (ID_EX_RegRT_i == IF_ID_RegRT_i));
  end

  // Next state, watchdog counter, freeze condition and raw memory request.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    freeze_c = 1'b0;
    req_c    = 1'b0;
    case (state_q)
      RUN: begin
        req_c = MEM_access_i;
        if (MEM_access_i && !dmem_ack_i) begin
          freeze_c = 1'b1;
          state_d  = MEM_WAIT;
          wait_d   = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        req_c = 1'b1;
        if (dmem_ack_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          freeze_c = 1'b1;
          if (wait_q == WAIT_W'(TIMEOUT)) begin
            state_d = ERR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ERR: begin
        freeze_c = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Saturating stall counter; ERR cycles are not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != ERR) && (freeze_c || load_use_c) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline controls; priority reset > ERR/freeze > load-use > branch flush.
  always_comb begin
    dmem_req_o     = 1'b0;
    PC_we_o        = 1'b0;
    IF_ID_we_o     = 1'b0;
    IF_ID_flush_o  = 1'b0;
    ID_EX_we_o     = 1'b0;
    ID_EX_bubble_o = 1'b0;
    EX_MEM_we_o    = 1'b0;
    MEM_WB_we_o    = 1'b0;
    if (rst_i) begin
      dmem_req_o = req_c;
      if (!freeze_c) begin
        PC_we_o     = 1'b1;
        IF_ID_we_o  = 1'b1;
        ID_EX_we_o  = 1'b1;
        EX_MEM_we_o = 1'b1;
        MEM_WB_we_o = 1'b1;
        if (load_use_c) begin
          // Hold PC/IF_ID; a pending branch is re-evaluated next cycle.
          PC_we_o        = 1'b0;
          IF_ID_we_o     = 1'b0;
          ID_EX_bubble_o = 1'b1;
        end else if (Branch_taken_i) begin
          IF_ID_flush_o = 1'b1;
        end
      end
    end
  end

  // State, watchdog and counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err_o       = (state_q == ERR);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             ID_EX_MemRead_i;
  logic [4:0]       ID_EX_RegRT_i;
  logic [4:0]       IF_ID_RegRS_i;
  logic [4:0]       IF_ID_RegRT_i;
  logic             Branch_taken_i;
  logic             MEM_access_i;
  logic             dmem_ack_i;
  logic             dmem_req_o;
  logic             PC_we_o;
  logic             IF_ID_we_o;
  logic             IF_ID_flush_o;
  logic             ID_EX_we_o;
  logic             ID_EX_bubble_o;
  logic             EX_MEM_we_o;
  logic             MEM_WB_we_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RegRT_i(ID_EX_RegRT_i),
    .IF_ID_RegRS_i(IF_ID_RegRS_i), .IF_ID_RegRT_i(IF_ID_RegRT_i),
    .Branch_taken_i(Branch_taken_i), .MEM_access_i(MEM_access_i),
    .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
    .PC_we_o(PC_we_o), .IF_ID_we_o(IF_ID_we_o), .IF_ID_flush_o(IF_ID_flush_o),
    .ID_EX_we_o(ID_EX_we_o), .ID_EX_bubble_o(ID_EX_bubble_o),
    .EX_MEM_we_o(EX_MEM_we_o), .MEM_WB_we_o(MEM_WB_we_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Control word order: {pc, ifid, flush, idex, bubble, exmem, memwb, req}
  localparam logic [7:0] C_RUN    = 8'b1101_0110;
  localparam logic [7:0] C_LU     = 8'b0001_1110;
  localparam logic [7:0] C_BR     = 8'b1111_0110;
  localparam logic [7:0] C_FRZ    = 8'b0000_0001;
  localparam logic [7:0] C_OFF    = 8'b0000_0000;

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       br;
    logic       acc;
    logic       ack;
    logic [7:0] exp_ctl;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[13];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [7:0] ctl();
    return {PC_we_o, IF_ID_we_o, IF_ID_flush_o, ID_EX_we_o, ID_EX_bubble_o,
            EX_MEM_we_o, MEM_WB_we_o, dmem_req_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] id_rs,
                       input logic [4:0] id_rt, input logic br, input logic acc,
                       input logic ack);
    ID_EX_MemRead_i = mr;
    ID_EX_RegRT_i   = ex_rt;
    IF_ID_RegRS_i   = id_rs;
    IF_ID_RegRT_i   = id_rt;
    Branch_taken_i  = br;
    MEM_access_i    = acc;
    dmem_ack_i      = ack;
  endtask

  // Inputs change at posedge+2; combinational outputs sampled at posedge+6.
  task automatic next_edge();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    next_edge();
    next_edge();
    rst_i = 1'b1;
  endtask

  function automatic vec_t mk(input string nm, input logic mr, input logic [4:0] ex_rt,
                              input logic [4:0] id_rs, input logic [4:0] id_rt,
                              input logic br, input logic acc, input logic ack,
                              input logic [7:0] ec, input logic [3:0] en);
    vec_t v;
    v.name = nm; v.mr = mr; v.ex_rt = ex_rt; v.id_rs = id_rs; v.id_rt = id_rt;
    v.br = br; v.acc = acc; v.ack = ack; v.exp_ctl = ec; v.exp_cnt = en;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk("idle",          0, 5'd0, 5'd0,  5'd0,  0, 0, 0, C_RUN, 4'd0);
    vecs[1]  = mk("lu_rs",         1, 5'd5, 5'd5,  5'd0,  0, 0, 0, C_LU,  4'd1);
    vecs[2]  = mk("lu_r0",         1, 5'd0, 5'd0,  5'd0,  0, 0, 0, C_RUN, 4'd1);
    vecs[3]  = mk("lu_rt",         1, 5'd7, 5'd3,  5'd7,  0, 0, 0, C_LU,  4'd2);
    vecs[4]  = mk("no_memread",    0, 5'd7, 5'd7,  5'd7,  0, 0, 0, C_RUN, 4'd2);
    vecs[5]  = mk("no_match",      1, 5'd9, 5'd8,  5'd10, 0, 0, 0, C_RUN, 4'd2);
    vecs[6]  = mk("lu_and_branch", 1, 5'd5, 5'd5,  5'd0,  1, 0, 0, C_LU,  4'd3);
    vecs[7]  = mk("branch",        0, 5'd5, 5'd5,  5'd0,  1, 0, 0, C_BR,  4'd3);
    vecs[8]  = mk("zero_wait",     0, 5'd0, 5'd0,  5'd0,  0, 1, 1, C_RUN | 8'h01, 4'd3);
    vecs[9]  = mk("zw_branch",     0, 5'd0, 5'd0,  5'd0,  1, 1, 1, C_BR | 8'h01,  4'd3);
    vecs[10] = mk("zw_lu",         1, 5'd4, 5'd1,  5'd4,  0, 1, 1, C_LU | 8'h01,  4'd4);
    vecs[11] = mk("stray_ack",     0, 5'd0, 5'd0,  5'd0,  0, 0, 1, C_RUN, 4'd4);
    vecs[12] = mk("idle_end",      0, 5'd0, 5'd0,  5'd0,  0, 0, 0, C_RUN, 4'd4);

    // Reset state, with active inputs that must be masked
    rst_i = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    #4;
    chk("rst_ctl", 32'(ctl()), 32'(C_OFF));
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
    do_reset();

    // Ten idle cycles after release
    for (int i = 0; i < 10; i++) begin
      #4;
      chk("idle_ctl", 32'(ctl()), 32'(C_RUN));
      next_edge();
      chk("idle_cnt", 32'(stall_cnt_o), 32'd0);
    end

    // Table of single-cycle vectors, run back to back in RUN
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].mr, vecs[i].ex_rt, vecs[i].id_rs, vecs[i].id_rt,
            vecs[i].br, vecs[i].acc, vecs[i].ack);
      #4;
      chk({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].exp_ctl));
      next_edge();
      chk({vecs[i].name, "_cnt"}, 32'(stall_cnt_o), 32'(vecs[i].exp_cnt));
      chk({vecs[i].name, "_err"}, 32'(err_o), 32'd0);
    end

    // Memory access acked on the 4th cycle; load-use during freeze is masked
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 1) drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
      else        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, c == 3);
      #4;
      chk("mw_ctl", 32'(ctl()), (c == 3) ? 32'(C_RUN | 8'h01) : 32'(C_FRZ));
      next_edge();
      chk("mw_cnt", 32'(stall_cnt_o), (c == 3) ? 32'd3 : 32'(c + 1));
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #4;
    chk("mw_back_run", 32'(ctl()), 32'(C_RUN));
    next_edge();
    chk("mw_final_cnt", 32'(stall_cnt_o), 32'd3);

    // Watchdog: TIMEOUT=4, ERR on the 5th edge after request
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      #4;
      chk("to_frz_ctl", 32'(ctl()), 32'(C_FRZ));
      next_edge();
      chk("to_err", 32'(err_o), (e == 5) ? 32'd1 : 32'd0);
    end
    chk("to_cnt", 32'(stall_cnt_o), 32'd5);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1);
    for (int e = 0; e < 3; e++) begin
      #4;
      chk("err_ctl", 32'(ctl()), 32'(C_OFF));
      next_edge();
      chk("err_sticky", 32'(err_o), 32'd1);
      chk("err_cnt_hold", 32'(stall_cnt_o), 32'd5);
    end
    do_reset();
    #4;
    chk("err_cleared", 32'(err_o), 32'd0);
    chk("err_rst_ctl", 32'(ctl()), 32'(C_RUN));
    next_edge();

    // Counter saturation with a long load-use run
    do_reset();
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      next_edge();
      if (e == 14) chk("sat_14", 32'(stall_cnt_o), 32'd14);
    end
    #4;
    chk("sat_cnt", 32'(stall_cnt_o), 32'd15);
    chk("sat_ctl", 32'(ctl()), 32'(C_LU));
    next_edge();

    // Asynchronous reset mid-MEM_WAIT
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    next_edge();
    next_edge();
    chk("ar_pre_cnt", 32'(stall_cnt_o), 32'd2);
    #1;
    rst_i = 1'b0;
    #1;
    chk("ar_req_drop", 32'(ctl()), 32'(C_OFF));
    chk("ar_cnt_clr", 32'(stall_cnt_o), 32'd0);
    @(negedge clk_i);
    MEM_access_i = 1'b0;
    rst_i = 1'b1;
    next_edge();
    #4;
    chk("ar_run_ctl", 32'(ctl()), 32'(C_RUN));
    chk("ar_cnt_post", 32'(stall_cnt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enables and bubble/flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Inserts load-use bubbles and flushes IF_ID on a taken branch.
- Freezes the whole pipeline while a variable-latency data-memory access completes, through a req/ack handshake with a timeout watchdog.

Parameters:
- TIMEOUT, 255, max cycles spent in MEM_WAIT before entering ERR (1..65535).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- ID_EX_MemRead_i  input  1  instruction in EX is a load.
- ID_EX_RegRT_i  input  5  load destination register in EX.
- IF_ID_RegRS_i  input  5  rs of instruction in ID.
- IF_ID_RegRT_i  input  5  rt of instruction in ID.
- Branch_taken_i  input  1  branch resolved taken in ID.
- MEM_access_i  input  1  instruction in MEM performs a load or store.
- dmem_ack_i  input  1  data memory completes the current access this cycle.
- dmem_req_o  output  1  data memory access request.
- PC_we_o  output  1  PC write enable.
- IF_ID_we_o  output  1  IF_ID write enable.
- IF_ID_flush_o  output  1  IF_ID loads a NOP.
- ID_EX_we_o  output  1  ID_EX write enable.
- ID_EX_bubble_o  output  1  ID_EX loads zero control bits.
- EX_MEM_we_o  output  1  EX_MEM write enable.
- MEM_WB_we_o  output  1  MEM_WB write enable.
- err_o  output  1  sticky memory-timeout error.
- stall_cnt_o  output  CNT_W  saturating count of frozen or stalled cycles.

Behaviour:
- Registered state, 2-bit: RUN, MEM_WAIT, ERR. Registered wait counter, 16-bit. Registered stall_cnt_o.
- All enable, flush and bubble outputs are combinational from state and the current-cycle inputs. They act in the same cycle.
- Reset (rst_i=0, asynchronous):
  - state=RUN, wait counter=0, stall_cnt_o=0, err_o=0.
  - While rst_i=0: all *_we_o=0, flush=0, bubble=0, dmem_req_o=0.
  - Reset asserted mid-MEM_WAIT aborts the access immediately: dmem_req_o drops in the same cycle.
- freeze, defined as: (state==RUN && MEM_access_i && !dmem_ack_i) || (state==MEM_WAIT && !dmem_ack_i) || state==ERR.
- dmem_req_o = MEM_access_i in RUN; 1 in MEM_WAIT; 0 in ERR.
- RUN state:
  - MEM_access_i && dmem_ack_i: zero-wait access, no freeze.
  - MEM_access_i && !dmem_ack_i: freeze; next state MEM_WAIT; wait counter <= 1.
- MEM_WAIT state:
  - dmem_ack_i: freeze released this cycle, all stages advance, next state RUN.
  - Else, wait counter == TIMEOUT: next state ERR.
  - Else: wait counter increments.
- ERR state: terminal until reset. err_o=1, all enables 0.
- Freeze: PC_we_o, IF_ID_we_o, ID_EX_we_o, EX_MEM_we_o, MEM_WB_we_o all 0. flush=0, bubble=0. Every pipeline register holds its contents.
- load_use, defined as: ID_EX_MemRead_i && ID_EX_RegRT_i!=0 && (ID_EX_RegRT_i==IF_ID_RegRS_i || ID_EX_RegRT_i==IF_ID_RegRT_i).
- Not frozen, load_use=1: PC_we_o=0, IF_ID_we_o=0, ID_EX_bubble_o=1. ID_EX, EX_MEM and MEM_WB enables stay 1. IF_ID_flush_o is forced 0, because the branch is re-evaluated next cycle.
- Not frozen, load_use=0, Branch_taken_i=1: IF_ID_flush_o=1, all enables 1.
- Otherwise all enables are 1, flush=0, bubble=0.
- Priority: reset > ERR > freeze > load_use > branch flush.
- stall_cnt_o increments on each rising edge where state!=ERR and (freeze || load_use). It saturates at all-ones.

Test Plan:
- Reset release, then 10 cycles with all inputs 0 -> all *_we_o=1, flush=0, bubble=0, dmem_req_o=0, stall_cnt_o=0.
- ID_EX_MemRead_i=1, ID_EX_RegRT_i=5, IF_ID_RegRS_i=5 for 1 cycle -> PC_we_o=0, IF_ID_we_o=0, ID_EX_bubble_o=1, stall_cnt_o=1. Repeat with RegRT=0 -> no stall.
- load_use and Branch_taken_i together -> IF_ID_flush_o=0, bubble=1. Next cycle with load_use=0 and Branch_taken_i=1 -> IF_ID_flush_o=1.
- MEM_access_i=1, dmem_ack_i asserted 3 cycles later -> dmem_req_o=1 for 4 cycles, all enables 0 for 3 cycles, enables 1 on the ack cycle, stall_cnt_o=3, state back to RUN.
- TIMEOUT=4, MEM_access_i=1, ack never asserted -> ERR entered on the 5th edge after request, err_o=1, dmem_req_o=0, enables stuck 0 until rst_i pulse. After reset, err_o=0.
- rst_i pulsed low asynchronously mid-MEM_WAIT -> dmem_req_o=0 immediately, state RUN after release, stall_cnt_o=0.
